// File: rtl/fa_tag_lookup_ctrl.sv
// Sequencer for a fully-associative tag store: LOOKUP / FILL / INVAL / FLUSH,
// sharing one external one-hot->binary encoder for tag match and free-slot search.
module fa_tag_lookup_ctrl #(
    parameter int N_WAYS = 1024,
    parameter int IDX_W  = 10,
    parameter int TAG_W  = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [1:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic              rsp_evict,
    output logic [N_WAYS-1:0] enc_oht,
    input  logic [IDX_W-1:0]  enc_bin,
    input  logic              enc_vld
);

    typedef enum logic [1:0] {S_IDLE, S_MATCH, S_FREE, S_RESP} state_t;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_WAYS-1:0]   r_valid;
    logic [TAG_W-1:0]    r_tag [N_WAYS];
    logic [TAG_W-1:0]    r_tag_q;
    logic [1:0]          r_op_q;
    logic                r_hit_q;
    logic [IDX_W-1:0]    r_idx_q;
    logic                r_evict_q;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [N_WAYS-1:0]   r_enc_oht;

    logic                w_accept;
    logic [N_WAYS-1:0]   w_match;
    logic [N_WAYS-1:0]   w_free;
    logic [N_WAYS-1:0]   w_free_low;
    logic [IDX_W-1:0]    w_wr_idx;

    assign w_accept   = req_vld & req_rdy;
    assign w_free     = ~r_valid;
    assign w_free_low = w_free & (~w_free + N_WAYS'(1));
    assign w_wr_idx   = enc_vld ? enc_bin : r_rr_ptr;

    // Match is only consumed on the accept cycle, when r_tag_q is still being loaded,
    // so compare against the incoming tag directly.
    // NOTE: every variable assigned in always_comb gets a default first, or a latch is inferred.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            w_match[i] = r_valid[i] && (r_tag[i] == req_tag);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (req_op == OP_FLUSH) ? S_RESP : S_MATCH;
            S_MATCH: w_state_nxt = (r_op_q == OP_FILL && !enc_vld) ? S_FREE : S_RESP;
            S_FREE:  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_rdy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_rdy = 1'b0;
        rsp_vld = 1'b0;
        case (r_state)
            S_IDLE:  req_rdy = 1'b1;
            S_RESP:  rsp_vld = 1'b1;
            default: ;
        endcase
    end

    assign rsp_hit   = r_hit_q;
    assign rsp_idx   = r_idx_q;
    assign rsp_evict = r_evict_q;
    assign enc_oht   = r_enc_oht;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_rr_ptr  <= '0;
            r_hit_q   <= 1'b0;
            r_idx_q   <= '0;
            r_evict_q <= 1'b0;
            r_enc_oht <= '0;
            r_op_q    <= OP_LOOKUP;
            r_tag_q   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op_q    <= req_op;
                    r_tag_q   <= req_tag;
                    r_evict_q <= 1'b0;
                    if (req_op == OP_FLUSH) begin
                        r_valid <= '0;
                        r_hit_q <= 1'b0;
                        r_idx_q <= '0;
                    end else begin
                        r_enc_oht <= w_match;
                    end
                end
                S_MATCH: begin
                    r_hit_q <= enc_vld;
                    r_idx_q <= enc_vld ? enc_bin : '0;
                    if (r_op_q == OP_INVAL && enc_vld) r_valid[enc_bin] <= 1'b0;
                    if (r_op_q == OP_FILL && !enc_vld) r_enc_oht <= w_free_low;
                end
                S_FREE: begin
                    r_valid[w_wr_idx] <= 1'b1;
                    r_idx_q           <= w_wr_idx;
                    if (!enc_vld) begin
                        r_evict_q <= 1'b1;
                        r_rr_ptr  <= r_rr_ptr + IDX_W'(1);
                    end
                end
                S_RESP: r_enc_oht <= '0;
                default: ;
            endcase
        end
    end

    // NOTE: the tag array carries no reset; valid bits alone define what is stored.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_FREE) r_tag[w_wr_idx] <= r_tag_q;
    end

    a_enc_onehot: assert property (@(posedge clk) $onehot0(r_enc_oht));

endmodule
